// File: rtl/support_mem_loader_if.sv
// Stream-in / RAM-write bundle for the support memory loader.
// The slave modport is the loader's view; the master modport is the view of
// whatever feeds the byte stream and observes the write port.
interface support_mem_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        sys_en;
    logic [15:0] sys_A;
    logic [7:0]  sys_data;
    logic        sys_wr;
    logic        busy;
    logic        done;
    logic        error;

    modport slave (
        input  in_data, in_valid,
        output in_ready, sys_en, sys_A, sys_data, sys_wr, busy, done, error
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, sys_en, sys_A, sys_data, sys_wr, busy, done, error
    );
endinterface

// File: rtl/support_mem_loader.sv
// Support memory loader: parses HEADER, addr_hi, addr_lo, len_hi, len_lo and
// then len data bytes from a valid/ready byte stream, writing each data byte
// to consecutive addresses of the support RAM.
//
// Handshake: a byte transfers in a cycle where in_valid=1 and in_ready=1;
// in_ready is high in every state except FINISH and does not depend on
// in_valid. Writes, done and error are registered and appear the cycle after
// the byte (or event) that caused them.
module support_mem_loader #(
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    support_mem_loader_if.slave         bus,
    output logic [2:0]                  state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADRH   = 3'd1,
        ADRL   = 3'd2,
        LENH   = 3'd3,
        LENL   = 3'd4,
        DATA   = 3'd5,
        FINISH = 3'd6
    } state_t;

    state_t      state, state_next;
    logic [15:0] addr, addr_next;
    logic [15:0] len, len_next;      // remaining data bytes once in DATA
    logic [15:0] cnt, cnt_next;      // idle cycles since the last accepted byte
    logic [15:0] cnt_inc;
    logic        accept;
    logic        in_frame;
    logic        timeout;
    logic        wr_next, done_next, error_next, en_next;
    logic [15:0] a_next;
    logic [7:0]  data_next;

    assign bus.in_ready = (state != FINISH);
    assign bus.busy     = (state != IDLE);
    assign state_dbg    = state;

    assign accept   = bus.in_valid && bus.in_ready;
    assign in_frame = (state != IDLE) && (state != FINISH);
    assign cnt_inc  = cnt + 16'd1;
    // Abort once TIMEOUT consecutive in-frame cycles have passed with no byte.
    assign timeout  = in_frame && !accept && (cnt_inc == TIMEOUT);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output decode for the frame parser.
    always_comb begin
        state_next = state;
        addr_next  = addr;
        len_next   = len;
        cnt_next   = (accept || !in_frame) ? 16'd0 : cnt_inc;
        wr_next    = 1'b0;
        done_next  = 1'b0;
        error_next = 1'b0;
        a_next     = bus.sys_A;
        data_next  = bus.sys_data;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.in_data == HEADER) begin
                        state_next = ADRH;
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end
            ADRH: begin
                if (accept) begin
                    addr_next  = {bus.in_data, addr[7:0]};
                    state_next = ADRL;
                end
            end
            ADRL: begin
                if (accept) begin
                    addr_next  = {addr[15:8], bus.in_data};
                    state_next = LENH;
                end
            end
            LENH: begin
                if (accept) begin
                    len_next   = {bus.in_data, len[7:0]};
                    state_next = LENL;
                end
            end
            LENL: begin
                if (accept) begin
                    len_next = {len[15:8], bus.in_data};
                    if ({len[15:8], bus.in_data} == 16'd0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    wr_next   = 1'b1;
                    a_next    = addr;
                    data_next = bus.in_data;
                    addr_next = addr + 16'd1;
                    len_next  = len - 16'd1;
                    if (len == 16'd1) begin
                        state_next = FINISH;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (timeout) begin
            state_next = IDLE;
            error_next = 1'b1;
        end

        // Keep ownership through a write still in flight so sys_wr never
        // appears without sys_en.
        en_next = (state_next == DATA) || (state_next == FINISH) || wr_next;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr         <= 16'h0000;
            len          <= 16'h0000;
            cnt          <= 16'h0000;
            bus.sys_en   <= 1'b0;
            bus.sys_wr   <= 1'b0;
            bus.sys_A    <= 16'h0000;
            bus.sys_data <= 8'h00;
            bus.done     <= 1'b0;
            bus.error    <= 1'b0;
        end else begin
            addr         <= addr_next;
            len          <= len_next;
            cnt          <= cnt_next;
            bus.sys_en   <= en_next;
            bus.sys_wr   <= wr_next;
            bus.sys_A    <= a_next;
            bus.sys_data <= data_next;
            bus.done     <= done_next;
            bus.error    <= error_next;
        end
    end

endmodule
